wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-side master for the register file's single write port (rd_data, rd, wen).
- Accepts results from two producers, the ALU and the load/store unit, over valid/ready handshakes.
- Grants at most one result per cycle using round-robin and drives a registered write to the register file.
- Keeps a per-register busy scoreboard so issue logic can detect read-after-write hazards before reading rs1/rs2.

Parameters:
XLEN, 32, data width of a register / write data
NREG, 32, number of architectural registers
AW, 5, register index width (log2 NREG)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
alu_valid  input  1  ALU result available
alu_ready  output  1  ALU result accepted this cycle
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  load result available
lsu_ready  output  1  load result accepted this cycle
lsu_rd  input  AW  load destination register
lsu_data  input  XLEN  load result
iss_valid  input  1  an instruction writing iss_rd is issued this cycle
iss_rd  input  AW  destination of the issued instruction
busy  output  NREG  bit i = 1: register i has a write outstanding
wen  output  1  register file write enable (registered)
rd  output  AW  register file write index (registered)
rd_data  output  XLEN  register file write data (registered)

Behaviour:
- Interface decision: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous, any time): wen=0, rd=0, rd_data=0, busy=all 0, rr pointer=LSU-priority.
  - Handshakes in flight are dropped; producers re-present after release.
- Handshake rules:
  - A transfer occurs on a rising edge where valid&ready=1.
  - Producers hold valid, rd and data stable until accepted.
  - ready is combinational from valids and the rr pointer; valid must not depend on ready.
- Arbitration:
  - Only one source valid: that source is granted (ready=1).
  - Both valid: the source indicated by the rr pointer is granted; the other sees ready=0.
  - The pointer flips to the other source only after a contended grant.
  - Neither valid: no grant, both ready=0.
- Output timing:
  - A grant at edge N drives wen=1, rd=<granted rd>, rd_data=<granted data> for exactly the cycle after edge N.
  - wen=0 in any cycle following an edge with no grant.
  - rd and rd_data hold their last values while wen=0.
  - Back-to-back grants give continuous wen=1 with new rd/rd_data each cycle.
  - Latency from accept to register write is 1 cycle.
- x0 handling:
  - A granted result with rd=0 is accepted (ready=1) but produces wen=0.
  - busy[0] is constant 0; iss_rd=0 never sets it.
- Scoreboard:
  - At an edge, iss_valid=1 sets busy[iss_rd].
  - A grant for register r clears busy[r] at the same edge, so busy[r] falls as wen for r rises.
  - Same register set and cleared at one edge: set wins (the issued instruction is younger).
  - A grant whose rd is not busy is still written; busy stays 0.
  - Multiple issues to one register before writeback: a single busy bit; the first writeback clears it. Issue logic must not issue a second writer to a busy rd (WAW); this is not checked here.
- Width rules: rd_data is passed through unmodified; no sign or zero handling here.

Test Plan:
- Reset: assert rst_n=0 mid-stream with alu_valid=1 -> wen=0, rd=0, rd_data=0, busy=0 immediately; after release with lsu_valid=1, lsu_ready=1 first.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge N -> alu_ready=1 before N; after N: wen=1, rd=5, rd_data=0xDEADBEEF for one cycle, then wen=0.
- Contention: both valid for 4 cycles (lsu_rd=1..., alu_rd=2...) -> grants LSU, ALU, LSU, ALU; wen=1 continuously; rd sequence 1,2,1,2 delayed 1 cycle.
- x0: alu_valid=1, alu_rd=0, alu_data=0x12345678 -> alu_ready=1, wen stays 0, busy[0]=0.
- Scoreboard: iss_valid=1, iss_rd=7 at edge N -> busy[7]=1; LSU grant rd=7 at edge N+3 -> busy[7]=0 and wen=1, rd=7 in the same cycle.
- Set/clear collision: at one edge, grant rd=9 with iss_valid=1, iss_rd=9 -> busy[9] remains 1 and the write still occurs (wen=1, rd=9).

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin between ALU and LSU results into the register
// file's single write port, with a per-register busy scoreboard for hazard checks.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic [NREG-1:0] busy,
    output logic            wen,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] rd_data
);

    // alu_pri_reg = 1 means the ALU wins the next contended cycle
    logic            alu_pri_reg, alu_pri_next;
    logic            grant_alu, grant_lsu, grant_any;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            wen_reg, wen_next;
    logic [AW-1:0]   rd_reg;
    logic [XLEN-1:0] rd_data_reg;
    logic [NREG-1:0] busy_reg, busy_next;

    always_comb begin
        grant_alu    = alu_valid && (!lsu_valid || alu_pri_reg);
        grant_lsu    = lsu_valid && !grant_alu;
        grant_any    = grant_alu || grant_lsu;
        grant_rd     = grant_alu ? alu_rd : lsu_rd;
        grant_data   = grant_alu ? alu_data : lsu_data;
        alu_pri_next = alu_pri_reg;
        if (alu_valid && lsu_valid) begin
            alu_pri_next = grant_lsu;
        end
        // writes to x0 are accepted but never reach the register file
        wen_next = grant_any && (grant_rd != '0);
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                // set after clear: a same-edge issue belongs to a younger instruction
                assign busy_next[gi] = (iss_valid && (iss_rd == AW'(gi))) ||
                                       (busy_reg[gi] && !(wen_next && (grant_rd == AW'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_pri_reg <= 1'b0;
            wen_reg     <= 1'b0;
            rd_reg      <= '0;
            rd_data_reg <= '0;
            busy_reg    <= '0;
        end else begin
            alu_pri_reg <= alu_pri_next;
            wen_reg     <= wen_next;
            busy_reg    <= busy_next;
            if (wen_next) begin
                rd_reg      <= grant_rd;
                rd_data_reg <= grant_data;
            end
        end
    end

    assign wen     = wen_reg;
    assign rd      = rd_reg;
    assign rd_data = rd_data_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a transaction-level model of
// arbitration fairness, registered write-back and the busy scoreboard.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
    logic            alu_ready, lsu_ready;
    logic [AW-1:0]   alu_rd = '0, lsu_rd = '0, iss_rd = '0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic [NREG-1:0] busy;
    logic            wen;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_data;

    wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .wen(wen), .rd(rd), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int              last_winner;   // 0 = LSU won last contention, 1 = ALU
    bit              m_wen;
    int              m_rd;
    logic [XLEN-1:0] m_data;
    bit              m_busy [NREG];
    bit              got_alu, got_lsu;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] busy_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        last_winner = 1;
        m_wen = 0; m_rd = 0; m_data = '0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    endtask

    // One clock: check readies before the edge, advance model, check outputs after.
    task automatic cycle();
        bit ea, el;
        int wr;
        logic [XLEN-1:0] wd;
        #1;
        if (alu_valid && lsu_valid) begin
            ea = (last_winner == 0);
            el = !ea;
        end else begin
            ea = alu_valid;
            el = lsu_valid;
        end
        chk("alu_ready", alu_ready, ea);
        chk("lsu_ready", lsu_ready, el);
        got_alu = alu_ready;
        got_lsu = lsu_ready;
        @(posedge clk);
        if (alu_valid && lsu_valid) last_winner = ea ? 1 : 0;
        m_wen = 0;
        if (ea || el) begin
            wr = ea ? int'(alu_rd) : int'(lsu_rd);
            wd = ea ? alu_data : lsu_data;
            if (wr != 0) begin
                m_wen = 1; m_rd = wr; m_data = wd;
                m_busy[wr] = 0;
            end
        end
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
        #1;
        chk("wen", wen, m_wen);
        chk("rd", rd, m_rd);
        chk("rd_data", rd_data, m_data);
        chk("busy", busy, busy_vec());
        $display("t=%0t alu(v=%0b rdy=%0b) lsu(v=%0b rdy=%0b) iss(v=%0b rd=%0d) -> wen=%0b rd=%0d data=%08h busy=%08h",
                 $time, alu_valid, got_alu, lsu_valid, got_lsu, iss_valid, iss_rd, wen, rd, rd_data, busy);
    endtask

    // producers keep a pending result until it is accepted
    task automatic random_drive();
        if (got_alu || !alu_valid) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = AW'($urandom_range(0, NREG - 1));
            alu_data  = $urandom;
        end
        if (got_lsu || !lsu_valid) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_rd    = AW'($urandom_range(0, NREG - 1));
            lsu_data  = $urandom;
        end
        iss_valid = ($urandom_range(0, 3) == 0);
        iss_rd    = AW'($urandom_range(0, NREG - 1));
        got_alu = 0;
        got_lsu = 0;
    endtask

    int exp_seq [4] = '{1, 2, 1, 2};

    initial begin
        model_reset();
        got_alu = 0; got_lsu = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wen", wen, 1'b0);
        chk("reset_busy", busy, '0);
        rst_n = 1'b1;

        // short stream, then asynchronous reset in the middle of it
        for (int i = 0; i < 12; i++) begin
            random_drive();
            cycle();
        end
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hCAFE0001;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wen", wen, 1'b0);
        chk("async_rst_rd", rd, 0);
        chk("async_rst_data", rd_data, 0);
        chk("async_rst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        iss_valid = 1'b0;

        // contention straight after reset: LSU first, then alternate
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h1000_0000;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2000_0000;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("contend_wen", wen, 1'b1);
            chk("contend_rd", rd, exp_seq[i]);
            if (got_lsu) lsu_data = lsu_data + 1;
            if (got_alu) alu_data = alu_data + 1;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        cycle();

        // single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cycle();
        chk("single_ready", got_alu, 1'b1);
        chk("single_wen", wen, 1'b1);
        chk("single_rd", rd, 5);
        chk("single_data", rd_data, 32'hDEADBEEF);
        alu_valid = 1'b0;
        cycle();
        chk("single_after_wen", wen, 1'b0);

        // write to x0 is consumed silently
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
        cycle();
        chk("x0_ready", got_alu, 1'b1);
        chk("x0_wen", wen, 1'b0);
        chk("x0_busy0", busy[0], 1'b0);
        chk("x0_hold_data", rd_data, 32'hDEADBEEF);
        alu_valid = 1'b0;

        // scoreboard: issue r7, write it back three edges later
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        iss_valid = 1'b0;
        chk("sb_set", busy[7], 1'b1);
        cycle();
        cycle();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
        cycle();
        chk("sb_clear", busy[7], 1'b0);
        chk("sb_wen", wen, 1'b1);
        chk("sb_rd", rd, 7);
        lsu_valid = 1'b0;

        // same-edge set and clear of r9: set wins, write still happens
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0999;
        iss_valid = 1'b1; iss_rd = 5'd9;
        cycle();
        chk("coll_busy", busy[9], 1'b1);
        chk("coll_wen", wen, 1'b1);
        chk("coll_rd", rd, 9);
        lsu_valid = 1'b0; iss_valid = 1'b0;
        cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            random_drive();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
